// File: rtl/mem_rd_arbiter_pkg.sv
// mem_rd_arbiter_pkg: shared widths, arbiter FSM state encodings and helpers
package mem_rd_arbiter_pkg;

    localparam int ADDR_SIZE  = 31;
    localparam int INSTR_SIZE = 31;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT_F = 2'd1;
    localparam logic [1:0] ARB_GRANT_L = 2'd2;
    localparam logic [1:0] ARB_RESP    = 2'd3;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
        return (v == max) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts cycles spent waiting on memory and flags expiry
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Restart on load, otherwise advance once per waiting cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (load) cnt <= '0;
        else if (count) cnt <= cnt + W'(1);
    end

    assign expire = count && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one memory read port between fetch and load masters (optional watchdog: MEM_ARB_TIMEOUT_EN)
import mem_rd_arbiter_pkg::*;

module mem_rd_arbiter #(
    parameter int ADDR_W     = ADDR_SIZE + 1,
    parameter int DATA_W     = INSTR_SIZE + 1,
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_rd_enable,
    input  logic [ADDR_W-1:0] f_rd_addr,
    output logic              f_rd_ready,
    output logic [DATA_W-1:0] f_rd_data,
    input  logic              f_flush,
    input  logic              l_rd_enable,
    input  logic [ADDR_W-1:0] l_rd_addr,
    output logic              l_rd_ready,
    output logic [DATA_W-1:0] l_rd_data,
    output logic              l_rd_error,
    output logic              f_rd_error,
    output logic              mem_rd_enable,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_ready
);

    logic [1:0]        state;
    logic [3:0]        starve_cnt;
    logic              kill;
    logic              f_req, l_req, pick_f, in_grant, aborted, done, f_kill;
    logic [DATA_W-1:0] rsp_data;

    // A flushed fetch never competes; fetch wins a tie only once loads have starved it
    assign f_req    = f_rd_enable & ~f_flush;
    assign l_req    = l_rd_enable;
    assign pick_f   = f_req & (~l_req | (starve_cnt == 4'(MAX_CONSEC)));
    assign in_grant = (state == ARB_GRANT_F) || (state == ARB_GRANT_L);
    assign done     = in_grant & (mem_rd_ready | aborted);
    assign f_kill   = kill | f_flush;
    assign rsp_data = mem_rd_ready ? mem_rd_data : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    logic expire;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (state == ARB_IDLE),
        .count  (in_grant),
        .expire (expire)
    );

    assign aborted = in_grant & ~mem_rd_ready & expire;
`else
    assign aborted    = 1'b0;
    assign f_rd_error = 1'b0;
    assign l_rd_error = 1'b0;
`endif

    // Arbitration, single outstanding memory transaction and response routing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARB_IDLE;
            starve_cnt    <= '0;
            kill          <= 1'b0;
            mem_rd_enable <= 1'b0;
            mem_rd_addr   <= '0;
            f_rd_ready    <= 1'b0;
            f_rd_data     <= '0;
            l_rd_ready    <= 1'b0;
            l_rd_data     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            f_rd_error    <= 1'b0;
            l_rd_error    <= 1'b0;
`endif
        end else begin
            f_rd_ready <= 1'b0;
            l_rd_ready <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            f_rd_error <= 1'b0;
            l_rd_error <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (pick_f) begin
                        state         <= ARB_GRANT_F;
                        mem_rd_addr   <= f_rd_addr;
                        mem_rd_enable <= 1'b1;
                        starve_cnt    <= '0;
                    end else if (l_req) begin
                        state         <= ARB_GRANT_L;
                        mem_rd_addr   <= l_rd_addr;
                        mem_rd_enable <= 1'b1;
                        if (f_req) starve_cnt <= sat_inc(starve_cnt, 4'(MAX_CONSEC));
                    end
                end
                ARB_GRANT_F: begin
                    if (f_flush) kill <= 1'b1;
                    if (done) begin
                        state         <= ARB_RESP;
                        mem_rd_enable <= 1'b0;
                        if (!f_kill) begin
                            f_rd_ready <= 1'b1;
                            f_rd_data  <= rsp_data;
`ifdef MEM_ARB_TIMEOUT_EN
                            f_rd_error <= aborted;
`endif
                        end
                    end
                end
                ARB_GRANT_L: begin
                    if (done) begin
                        state         <= ARB_RESP;
                        mem_rd_enable <= 1'b0;
                        l_rd_ready    <= 1'b1;
                        l_rd_data     <= rsp_data;
`ifdef MEM_ARB_TIMEOUT_EN
                        l_rd_error    <= aborted;
`endif
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed scoreboard bench for the memory read arbiter
module tb_mem_rd_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_rd_enable = 1'b0, f_flush = 1'b0, l_rd_enable = 1'b0;
    logic [31:0] f_rd_addr = '0, l_rd_addr = '0;
    logic        f_rd_ready, l_rd_ready, f_rd_error, l_rd_error, mem_rd_enable;
    logic [31:0] f_rd_data, l_rd_data, mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd_ready = 1'b0;

    mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_CONSEC(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .f_rd_enable(f_rd_enable), .f_rd_addr(f_rd_addr), .f_rd_ready(f_rd_ready),
        .f_rd_data(f_rd_data), .f_flush(f_flush),
        .l_rd_enable(l_rd_enable), .l_rd_addr(l_rd_addr), .l_rd_ready(l_rd_ready),
        .l_rd_data(l_rd_data), .l_rd_error(l_rd_error), .f_rd_error(f_rd_error),
        .mem_rd_enable(mem_rd_enable), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int mem_lat = 2, mcnt = 0, rdy_cyc = 0;
    int f_seen = 0, l_seen = 0, g_seen = 0;
    int rise_cyc = 0, drop_cyc = 0, gap = 0, turn = 0, hi_len = 0, f_rdy_cyc = 0;
    logic prev_en = 1'b0;
    logic [32:0] f_q[$], l_q[$];
    logic [31:0] g_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    // Memory: completes after mem_lat cycles of visible enable (0 = never)
    always @(negedge clk) begin
        if (!reset || !mem_rd_enable) begin
            mcnt = 0;
            mem_rd_ready = 1'b0;
        end else begin
            mcnt++;
            mem_rd_ready = (mem_lat != 0) && (mcnt == mem_lat);
            mem_rd_data = mem_rd_ready ? data_of(mem_rd_addr) : 32'h0BAD_0BAD;
            if (mem_rd_ready) rdy_cyc = cyc;
        end
    end

    // Monitor: grants and responses are popped from the scoreboard as they appear
    always @(negedge clk) begin
        if (mem_rd_enable && !prev_en) begin
            g_seen++;
            gap = cyc - drop_cyc;
            turn = cyc - rdy_cyc;
            rise_cyc = cyc;
            if (g_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL grant_unexpected: got grant at %h, required none", mem_rd_addr);
            end else chk("grant_addr", 64'(mem_rd_addr), 64'(g_q.pop_front()));
        end
        if (!mem_rd_enable && prev_en) begin
            drop_cyc = cyc;
            hi_len = cyc - rise_cyc;
        end
        prev_en = mem_rd_enable;
        if (f_rd_ready) begin
            f_seen++;
            f_rdy_cyc = cyc;
            if (f_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL f_rsp_unexpected: got data %h, required no response", f_rd_data);
            end else chk("f_rsp", 64'({f_rd_error, f_rd_data}), 64'(f_q.pop_front()));
        end
        if (l_rd_ready) begin
            l_seen++;
            if (l_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL l_rsp_unexpected: got data %h, required no response", l_rd_data);
            end else chk("l_rsp", 64'({l_rd_error, l_rd_data}), 64'(l_q.pop_front()));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input int target, input string nm);
        int n = 0;
        while ((which == 0 ? f_seen : which == 1 ? l_seen : g_seen) < target && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_vec++; n_err++;
            $display("FAIL %s: timed out, count below required %0d", nm, target);
        end
    endtask

    initial begin
        int t0, fs;
        repeat (3) step();
        chk("reset_ctrl", 64'({mem_rd_enable, f_rd_ready, l_rd_ready, f_rd_error, l_rd_error}), 64'd0);
        chk("reset_data", {f_rd_data, l_rd_data}, 64'd0);
        reset = 1'b1;
        repeat (2) step();

        // fetch alone: 4 cycles from request to data
        mem_lat = 2;
        g_q.push_back(32'h40);
        f_q.push_back({1'b0, 32'hDEADBEEF});
        f_rd_addr = 32'h40; f_rd_enable = 1'b1; t0 = cyc;
        wait_for(0, 1, "fetch_alone");
        f_rd_enable = 1'b0;
        chk("fetch_latency", 64'(f_rdy_cyc - t0 + 1), 64'd4);
        repeat (2) step();

        // back-to-back loads: enable idles through RESP and the arbitration cycle
        g_q.push_back(32'h10); l_q.push_back({1'b0, 32'hC0DE0010});
        g_q.push_back(32'h14); l_q.push_back({1'b0, 32'hC0DE0014});
        l_rd_addr = 32'h10; l_rd_enable = 1'b1;
        wait_for(1, 1, "load_10");
        l_rd_addr = 32'h14;
        wait_for(1, 2, "load_14");
        l_rd_enable = 1'b0;
        chk("b2b_enable_low_gap", 64'(gap), 64'd2);
        chk("b2b_turnaround", 64'(turn), 64'd3);
        repeat (2) step();

        // flush during GRANT_F: memory completes, fetch response suppressed
        fs = f_seen;
        g_q.push_back(32'h100);
        g_q.push_back(32'h180); l_q.push_back({1'b0, 32'hC0DE0180});
        f_rd_addr = 32'h100; f_rd_enable = 1'b1;
        wait_for(2, g_seen + 1, "flush_grant");
        f_flush = 1'b1; f_rd_enable = 1'b0;
        l_rd_addr = 32'h180; l_rd_enable = 1'b1;
        step();
        f_flush = 1'b0;
        wait_for(1, l_seen + 1, "flush_load");
        l_rd_enable = 1'b0;
        chk("flush_no_f_ready", 64'(f_seen), 64'(fs));
        chk("flush_turnaround", 64'(turn), 64'd3);
        repeat (2) step();

        // contention: L,L,L,L,F,L,L,L,L,F
        mem_lat = 1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                g_q.push_back(32'h300);
                l_q.push_back({1'b0, 32'hC0DE0300});
            end
            g_q.push_back(32'h200);
            f_q.push_back({1'b0, 32'hC0DE0200});
        end
        fs = f_seen;
        f_rd_addr = 32'h200; l_rd_addr = 32'h300;
        f_rd_enable = 1'b1; l_rd_enable = 1'b1;
        wait_for(0, fs + 2, "contention");
        f_rd_enable = 1'b0; l_rd_enable = 1'b0;
        chk("contention_pending", 64'(g_q.size()), 64'd0);
        repeat (2) step();

        // reset in the middle of GRANT_L: abandoned, no l_rd_ready
        mem_lat = 10;
        fs = l_seen;
        g_q.push_back(32'h20);
        l_rd_addr = 32'h20; l_rd_enable = 1'b1;
        wait_for(2, g_seen + 1, "reset_grant");
        step();
        reset = 1'b0;
        #1;
        chk("async_reset_ctrl", 64'({mem_rd_enable, f_rd_ready, l_rd_ready, f_rd_error, l_rd_error}), 64'd0);
        chk("async_reset_addr", 64'(mem_rd_addr), 64'd0);
        chk("async_reset_data", {f_rd_data, l_rd_data}, 64'd0);
        l_rd_enable = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (4) step();
        chk("post_reset_idle", 64'(mem_rd_enable), 64'd0);
        chk("post_reset_no_ready", 64'(l_seen), 64'(fs));
        mem_lat = 1;
        g_q.push_back(32'h24); l_q.push_back({1'b0, 32'hC0DE0024});
        l_rd_addr = 32'h24; l_rd_enable = 1'b1;
        wait_for(1, l_seen + 1, "post_reset_load");
        l_rd_enable = 1'b0;
        repeat (2) step();

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never answers: abort after TIMEOUT grant cycles with error
        mem_lat = 0;
        g_q.push_back(32'h500); l_q.push_back({1'b1, 32'h0});
        l_rd_addr = 32'h500; l_rd_enable = 1'b1;
        wait_for(1, l_seen + 1, "timeout");
        l_rd_enable = 1'b0;
        chk("timeout_enable_cycles", 64'(hi_len), 64'(TO));
        repeat (2) step();
`endif

        chk("scoreboard_empty", 64'({f_q.size(), l_q.size(), g_q.size()} != 0), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

endmodule
